// File: rtl/forward_hazard_unit_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard unit.
// Register specifiers are held at a fixed maximum width so the slot types stay parameter-free.
package forward_hazard_unit_pkg;

   localparam logic [1:0] FWD_REG   = 2'd0;
   localparam logic [1:0] FWD_EXMEM = 2'd1;
   localparam logic [1:0] FWD_MEMWB = 2'd2;

   localparam int unsigned REG_MAX_BITS = 8;

   typedef logic [REG_MAX_BITS-1:0] reg_t;

   typedef struct packed {
      reg_t rd;
      logic regwrite;
      logic memread;
      reg_t rs;
      reg_t rt;
   } slot_t;

   // EX/MEM and MEM/WB only need the write-back destination.
   typedef struct packed {
      reg_t rd;
      logic regwrite;
   } wb_slot_t;

   localparam slot_t    SLOT_EMPTY = '0;
   localparam wb_slot_t WB_EMPTY   = '0;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding comparator: picks the youngest in-flight writer of src.
// Register $0 is never forwarded.
module fwd_select
   import forward_hazard_unit_pkg::*;
(
   input  reg_t       src,
   input  wb_slot_t   exmem,
   input  wb_slot_t   memwb,
   output logic [1:0] sel
);

   always_comb begin
      sel = FWD_REG;
      if (exmem.regwrite && (exmem.rd != '0) && (exmem.rd == src))
         sel = FWD_EXMEM;
      else if (memwb.regwrite && (memwb.rd != '0) && (memwb.rd == src))
         sel = FWD_MEMWB;
   end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline: shadows the
// ID/EX, EX/MEM and MEM/WB destination info and drives EX operand mux selects.
module forward_hazard_unit
   import forward_hazard_unit_pkg::*;
#(
   parameter int unsigned REG_BITS = 5,
   parameter int unsigned CNT_BITS = 32
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic [REG_BITS-1:0] id_rd,
   input  logic                id_regwrite,
   input  logic                id_memread,
   input  logic                flush,
   output logic [1:0]          ex_ctrl_a,
   output logic [1:0]          ex_ctrl_b,
   output logic                stall,
   output logic                bubble,
   output logic [CNT_BITS-1:0] stall_count
);

   slot_t               idex;
   slot_t               id_slot;
   wb_slot_t            exmem;
   wb_slot_t            memwb;
   logic                hazard;
   logic [CNT_BITS-1:0] cnt;

   always_comb begin
      id_slot                   = SLOT_EMPTY;
      id_slot.rs[REG_BITS-1:0]  = id_rs;
      id_slot.rt[REG_BITS-1:0]  = id_rt;
      id_slot.rd[REG_BITS-1:0]  = id_rd;
      id_slot.regwrite          = id_regwrite;
      id_slot.memread           = id_memread;
   end

   always_comb begin
      hazard = id_valid && idex.memread && (idex.rd != '0) &&
               ((idex.rd == id_slot.rs) || (idex.rd == id_slot.rt));
      // A taken branch kills the consumer anyway, so it never costs a stall.
      stall  = hazard && !flush;
      bubble = stall || flush;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         idex  <= SLOT_EMPTY;
         exmem <= WB_EMPTY;
         memwb <= WB_EMPTY;
         cnt   <= '0;
      end else begin
         memwb <= exmem;
         exmem <= '{rd: idex.rd, regwrite: idex.regwrite};
         idex  <= (id_valid && !bubble) ? id_slot : SLOT_EMPTY;
         if (stall)
            cnt <= cnt + CNT_BITS'(1);
      end
   end

   assign stall_count = cnt;

   fwd_select u_sel_a (
      .src   (idex.rs),
      .exmem (exmem),
      .memwb (memwb),
      .sel   (ex_ctrl_a)
   );

   fwd_select u_sel_b (
      .src   (idex.rt),
      .exmem (exmem),
      .memwb (memwb),
      .sel   (ex_ctrl_b)
   );

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed pipeline snippets with literal expectations,
// then random instruction streams checked every cycle against a stage-array model.
module tb_forward_hazard_unit;

   logic        clock;
   logic        reset_n;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_regwrite, id_memread, flush;
   logic [1:0]  ex_ctrl_a, ex_ctrl_b;
   logic        stall, bubble;
   logic [31:0] stall_count;

   int nchk  = 0;
   int npass = 0;

   forward_hazard_unit #(.REG_BITS(5), .CNT_BITS(32)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_memread  (id_memread),
      .flush       (flush),
      .ex_ctrl_a   (ex_ctrl_a),
      .ex_ctrl_b   (ex_ctrl_b),
      .stall       (stall),
      .bubble      (bubble),
      .stall_count (stall_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   typedef struct {
      bit v;
      int rs, rt, rd;
      bit rw, mr;
   } instr_t;

   instr_t      stage [3];   // 0 = EX, 1 = MEM, 2 = WB
   bit   [31:0] m_cnt;

   function automatic instr_t empty_instr();
      instr_t e;
      e.v = 0; e.rs = 0; e.rt = 0; e.rd = 0; e.rw = 0; e.mr = 0;
      return e;
   endfunction

   function automatic int m_sel(int src);
      if (src == 0) return 0;
      if (stage[1].v && stage[1].rw && stage[1].rd == src) return 1;
      if (stage[2].v && stage[2].rw && stage[2].rd == src) return 2;
      return 0;
   endfunction

   function automatic bit m_stall();
      bit dep;
      dep = id_valid && stage[0].v && stage[0].mr && stage[0].rd != 0 &&
            (stage[0].rd == int'(id_rs) || stage[0].rd == int'(id_rt));
      return dep && !flush;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 3; i++) stage[i] = empty_instr();
         m_cnt = 0;
      end else begin
         bit st, bub;
         instr_t cur;
         st  = m_stall();
         bub = st || flush;
         if (st) m_cnt = m_cnt + 1;
         stage[2] = stage[1];
         stage[1] = stage[0];
         if (id_valid && !bub) begin
            cur.v = 1; cur.rs = int'(id_rs); cur.rt = int'(id_rt); cur.rd = int'(id_rd);
            cur.rw = id_regwrite; cur.mr = id_memread;
            stage[0] = cur;
         end else begin
            stage[0] = empty_instr();
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   always @(negedge clock) begin
      if (reset_n) begin
         bit st;
         st = m_stall();
         chk("model ex_ctrl_a", int'(ex_ctrl_a), m_sel(stage[0].rs));
         chk("model ex_ctrl_b", int'(ex_ctrl_b), m_sel(stage[0].rt));
         chk("model stall", int'(stall), int'(st));
         chk("model bubble", int'(bubble), int'(st || flush));
         chk("model stall_count", int'(stall_count), int'(m_cnt));
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input bit v, input int rs, input int rt, input int rd,
                        input bit rw, input bit mr, input bit fl);
      @(posedge clock);
      #1;
      id_valid    = v;
      id_rs       = 5'(rs);
      id_rt       = 5'(rt);
      id_rd       = 5'(rd);
      id_regwrite = rw;
      id_memread  = mr;
      flush       = fl;
   endtask

   task automatic nop();
      issue(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain();
      repeat (3) nop();
   endtask

   // Literal checks happen just after the negedge of the current cycle.
   task automatic mid();
      #5;
   endtask

   initial begin
      int cnt_before;
      reset_n = 1'b0;
      id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_regwrite = 0; id_memread = 0; flush = 0;
      #2;
      chk("reset ex_ctrl_a", int'(ex_ctrl_a), 0);
      chk("reset ex_ctrl_b", int'(ex_ctrl_b), 0);
      chk("reset stall", int'(stall), 0);
      chk("reset bubble", int'(bubble), 0);
      chk("reset stall_count", int'(stall_count), 0);
      #10 reset_n = 1'b1;

      // add $3,$1,$2 ; sub $4,$3,$5
      drain();
      issue(1, 1, 2, 3, 1, 0, 0);
      issue(1, 3, 5, 4, 1, 0, 0); mid();
      chk("exmem fwd no stall", int'(stall), 0);
      nop(); mid();
      chk("exmem fwd a", int'(ex_ctrl_a), 1);
      chk("exmem fwd b", int'(ex_ctrl_b), 0);

      // add $3 ; nop ; or $6,$5,$3
      drain();
      issue(1, 1, 2, 3, 1, 0, 0);
      nop();
      issue(1, 5, 3, 6, 1, 0, 0);
      nop(); mid();
      chk("memwb fwd a", int'(ex_ctrl_a), 0);
      chk("memwb fwd b", int'(ex_ctrl_b), 2);

      // add $3 ; addi $3 ; and $7,$3,$3
      drain();
      issue(1, 1, 2, 3, 1, 0, 0);
      issue(1, 1, 0, 3, 1, 0, 0);
      issue(1, 3, 3, 7, 1, 0, 0);
      nop(); mid();
      chk("priority a", int'(ex_ctrl_a), 1);
      chk("priority b", int'(ex_ctrl_b), 1);

      // lw $8 ; add $9,$8,$1 (held one cycle)
      drain();
      issue(1, 1, 0, 8, 1, 1, 0);
      issue(1, 8, 1, 9, 1, 0, 0); mid();
      chk("load-use stall", int'(stall), 1);
      chk("load-use bubble", int'(bubble), 1);
      chk("load-use count before", int'(stall_count), 0);
      issue(1, 8, 1, 9, 1, 0, 0); mid();
      chk("load-use stall released", int'(stall), 0);
      chk("load-use count after", int'(stall_count), 1);
      nop(); mid();
      chk("load-use fwd a", int'(ex_ctrl_a), 2);
      chk("load-use fwd b", int'(ex_ctrl_b), 0);

      // lw $0 ; add $0 ; or $5,$0,$0
      drain();
      issue(1, 1, 0, 0, 1, 1, 0);
      issue(1, 0, 0, 0, 1, 0, 0); mid();
      chk("zero reg no stall", int'(stall), 0);
      issue(1, 0, 0, 5, 1, 0, 0);
      nop(); mid();
      chk("zero reg sel a", int'(ex_ctrl_a), 0);
      chk("zero reg sel b", int'(ex_ctrl_b), 0);

      // lw $8 ; add $9,$8,$1 with a taken branch in the same cycle
      drain();
      cnt_before = int'(stall_count);
      issue(1, 1, 0, 8, 1, 1, 0);
      issue(1, 8, 1, 9, 1, 0, 1); mid();
      chk("flush stall", int'(stall), 0);
      chk("flush bubble", int'(bubble), 1);
      nop(); mid();
      chk("flush count", int'(stall_count), cnt_before);

      // reset dropped while a load-use stall is active
      drain();
      issue(1, 1, 0, 8, 1, 1, 0);
      issue(1, 8, 8, 9, 1, 0, 0); #2;
      chk("pre-reset stall", int'(stall), 1);
      reset_n = 1'b0; #1;
      chk("async reset stall", int'(stall), 0);
      chk("async reset bubble", int'(bubble), 0);
      chk("async reset a", int'(ex_ctrl_a), 0);
      chk("async reset b", int'(ex_ctrl_b), 0);
      chk("async reset count", int'(stall_count), 0);
      #10 reset_n = 1'b1;
      issue(1, 8, 8, 10, 1, 0, 0);
      nop(); mid();
      chk("post-reset no fwd a", int'(ex_ctrl_a), 0);
      chk("post-reset no fwd b", int'(ex_ctrl_b), 0);

      // random streams over a small register window to provoke matches
      for (int i = 0; i < 400; i++) begin
         bit v, mr, rw;
         mr = ($urandom_range(0, 3) == 0);
         rw = mr || ($urandom_range(0, 3) != 0);
         v  = ($urandom_range(0, 7) != 0);
         issue(v, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
               int'($urandom_range(0, 5)), rw, mr, ($urandom_range(0, 7) == 0));
      end
      drain();

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
